rmii_frame_forwarder: RTL and testbench

//  Parametrised RMII/MII frame forwarder: detects frame start on the PHY receive side, buffers units in a

---
 rtl/rmii_frame_forwarder.sv | 154 +++++++++++++++
 tb/tb_rmii_frame_forwarder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_forwarder.sv
// RMII/MII frame forwarder: accepts a frame on the PHY receive side and replays it on the transmit side
// through a fixed-latency FIFO, with abort/truncate/drop handling, inter-frame gap and frame statistics.
module rmii_frame_forwarder #(
  parameter int DW         = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LATENCY    = 4,
  parameter int MAX_UNITS  = 6088,
  parameter int IFG_CYCLES = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          close_connection,
  input  logic [DW-1:0] rxd,
  input  logic          crs_dv,
  input  logic          sigdet,
  output logic [DW-1:0] txd,
  output logic          tx_en,
  output logic          data_capture,
  output logic [15:0]   frame_count,
  output logic [15:0]   drop_count,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = $clog2(MAX_UNITS + 2);
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [DW-1:0] SP = {(DW/2){2'b01}};

  typedef enum logic [2:0] {
    S_IDLE, S_FORWARD, S_DRAIN, S_ABORT, S_DROP, S_IFG
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   lat_cnt;
  logic [UW-1:0] unit_cnt;
  logic [IW-1:0] ifg_cnt;
  logic          dv_q;

  logic sp_hit, end_det, lat_done, fifo_empty, fifo_full, abort_req;
  logic wr_req, wr_en, rd_en, flush, start, lat_step, frame_inc, drop_inc;

  assign sp_hit     = crs_dv && sigdet && (rxd == SP);
  assign end_det    = !crs_dv && !dv_q;
  assign lat_done   = (lat_cnt == (AW+1)'(LATENCY));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign abort_req  = close_connection || !sigdet || ((unit_cnt == UW'(MAX_UNITS)) && crs_dv);
  assign wr_en      = wr_req && !fifo_full;
  assign data_capture = (state == S_FORWARD);

  // NOTE: every output of this block gets a default first so no path leaves a value held, which would infer a latch.
  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    rd_en     = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    lat_step  = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sp_hit && close_connection) begin
          state_nxt = S_DROP;
          drop_inc  = 1'b1;
        end else if (sp_hit) begin
          state_nxt = S_FORWARD;
          wr_req    = 1'b1;
          start     = 1'b1;
        end
      end
      S_FORWARD: begin
        if (abort_req) begin
          // Abort beats a simultaneous end_det: the frame counts as dropped.
          state_nxt = S_ABORT;
          flush     = 1'b1;
        end else begin
          // The first low crs_dv cycle still carries data (RMII tail toggling).
          wr_req = crs_dv || dv_q;
          if (lat_done) rd_en = !fifo_empty;
          else          lat_step = 1'b1;
          if (end_det) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!lat_done) begin
          lat_step = 1'b1;
        end else if (!fifo_empty) begin
          rd_en = 1'b1;
        end else begin
          frame_inc = 1'b1;
          state_nxt = S_IFG;
        end
      end
      S_ABORT: begin
        drop_inc  = 1'b1;
        state_nxt = crs_dv ? S_DROP : S_IFG;
      end
      S_DROP: begin
        if (end_det) state_nxt = S_IFG;
      end
      S_IFG: begin
        if (ifg_cnt == IW'(IFG_CYCLES - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lat_cnt     <= '0;
      unit_cnt    <= '0;
      ifg_cnt     <= '0;
      dv_q        <= 1'b0;
      txd         <= '0;
      tx_en       <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      dv_q  <= crs_dv;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
      if (start)         lat_cnt <= (AW+1)'(1);
      else if (lat_step) lat_cnt <= lat_cnt + 1'b1;
      if (start)       unit_cnt <= UW'(1);
      else if (wr_req) unit_cnt <= unit_cnt + 1'b1;
      ifg_cnt <= (state == S_IFG) ? ifg_cnt + 1'b1 : '0;
      tx_en   <= rd_en;
      txd     <= rd_en ? mem[rd_ptr[AW-1:0]] : '0;
      if (wr_req && fifo_full) overflow <= 1'b1;
      if (frame_inc && frame_count != 16'hFFFF) frame_count <= frame_count + 1'b1;
      if (drop_inc && drop_count != 16'hFFFF)   drop_count  <= drop_count + 1'b1;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rxd;
  end

endmodule

// File: tb/tb_rmii_frame_forwarder.sv
// Bench for rmii_frame_forwarder: directed frame scenarios with random payloads, checked against a
// frame-level model (expected transmit stream = accepted units shifted by LATENCY, cut at any abort).
module tb_rmii_frame_forwarder;

  localparam int L2   = 4;
  localparam int L4   = 8;
  localparam int MAXU = 6088;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        cc, crs_dv, sigdet;
  logic [1:0]  rxd, txd;
  logic        tx_en, dcap, ovf;
  logic [15:0] fc, dc;

  logic        cc4, crs_dv4, sigdet4;
  logic [3:0]  rxd4, txd4;
  logic        tx_en4, dcap4, ovf4;
  logic [15:0] fc4, dc4;

  rmii_frame_forwarder dut (
    .clk(clk), .rst(rst), .close_connection(cc), .rxd(rxd), .crs_dv(crs_dv), .sigdet(sigdet),
    .txd(txd), .tx_en(tx_en), .data_capture(dcap), .frame_count(fc), .drop_count(dc), .overflow(ovf)
  );

  rmii_frame_forwarder #(.DW(4), .LATENCY(L4)) dut4 (
    .clk(clk), .rst(rst), .close_connection(cc4), .rxd(rxd4), .crs_dv(crs_dv4), .sigdet(sigdet4),
    .txd(txd4), .tx_en(tx_en4), .data_capture(dcap4), .frame_count(fc4), .drop_count(dc4), .overflow(ovf4)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_fc = 0;
  int exp_dc = 0;

  logic [3:0] units[$];
  logic [3:0] frame_a[$];
  logic [3:0] cap2_d[$], cap4_d[$];
  int         cap2_e[$], cap4_e[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then new inputs may be driven.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (tx_en)  begin cap2_d.push_back({2'b00, txd}); cap2_e.push_back(cyc); end
    if (tx_en4) begin cap4_d.push_back(txd4);         cap4_e.push_back(cyc); end
  endtask

  task automatic drive(input bit sel4, input bit dv, input logic [3:0] d, input bit c);
    if (sel4) begin crs_dv4 = dv; rxd4 = d;      cc4 = c; end
    else      begin crs_dv  = dv; rxd  = d[1:0]; cc  = c; end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic clear_caps();
    cap2_d.delete(); cap2_e.delete(); cap4_d.delete(); cap4_e.delete();
  endtask

  // Preamble 7 x 0x55 + SFD 0xD5, then random payload bytes, split LSB-first into dw-bit units.
  task automatic build_frame(input int dw, input int n_payload);
    logic [7:0] b;
    units.delete();
    for (int k = 0; k < 8 + n_payload; k++) begin
      b = (k < 7) ? 8'h55 : (k == 7) ? 8'hD5 : 8'($urandom);
      for (int j = 0; j < 8 / dw; j++)
        units.push_back(4'((b >> (j * dw)) & ((1 << dw) - 1)));
    end
  endtask

  // The last unit is presented with crs_dv already low (RMII tail), followed by one more low cycle.
  // abort_at pulses close_connection on that unit index (units.size() = on the end_det cycle).
  task automatic send_frame(input bit sel4, input int abort_at, output int s_edge);
    int n;
    n = units.size();
    s_edge = 0;
    for (int i = 0; i <= n; i++) begin
      drive(sel4, i < n - 1, (i < n) ? units[i] : 4'h0, i == abort_at);
      tick();
      if (i == 0) s_edge = cyc;
      if (i == 50 && abort_at < 0 && !sel4) check("data_capture mid-frame", dcap, 1);
    end
    drive(sel4, 1'b0, 4'h0, 1'b0);
  endtask

  // Expected: units[0 .. n_exp-1] on txd on consecutive cycles starting LATENCY after the first unit.
  task automatic verify_stream(input string tag, input bit sel4, input int s, input int n_exp);
    logic [3:0] dq[$];
    int eq[$];
    int lat, bad;
    if (sel4) begin dq = cap4_d; eq = cap4_e; lat = L4; end
    else      begin dq = cap2_d; eq = cap2_e; lat = L2; end
    check({tag, " tx_en cycles"}, dq.size(), n_exp);
    if (dq.size() > 0) begin
      check({tag, " first tx edge"}, eq[0], s + lat);
      check({tag, " tx span"}, eq[eq.size() - 1] - eq[0], dq.size() - 1);
      bad = 0;
      for (int i = 0; i < dq.size() && i < n_exp; i++)
        if (dq[i] !== units[i]) bad++;
      check({tag, " txd data mismatches"}, bad, 0);
    end
  endtask

  initial begin
    int s, sa, sb, n;
    logic [1:0] v;
    rst = 1'b1;
    sigdet = 1'b1; sigdet4 = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (3) tick();
    check("reset tx_en", tx_en, 0);
    check("reset txd", txd, 0);
    check("reset data_capture", dcap, 0);
    check("reset frame_count", fc, 0);
    check("reset drop_count", dc, 0);
    check("reset overflow", ovf, 0);
    check("reset tx_en dw4", tx_en4, 0);
    rst = 1'b0;
    idle(5);

    // Normal 64-byte frame.
    build_frame(2, 64);
    clear_caps();
    send_frame(1'b0, -1, s);
    idle(70);
    verify_stream("t1", 1'b0, s, 288);
    exp_fc++;
    check("t1 frame_count", fc, exp_fc);
    check("t1 drop_count", dc, exp_dc);
    check("t1 data_capture after frame", dcap, 0);

    // Blocked at the start pattern, then a normal frame after the gap.
    build_frame(2, 32);
    clear_caps();
    send_frame(1'b0, 0, s);
    idle(60);
    verify_stream("t2 drop", 1'b0, s, 0);
    exp_dc++;
    check("t2 drop_count", dc, exp_dc);
    build_frame(2, 16);
    clear_caps();
    send_frame(1'b0, -1, s);
    idle(70);
    verify_stream("t2 next", 1'b0, s, units.size());
    exp_fc++;
    check("t2 frame_count", fc, exp_fc);

    // Filter verdict at unit 100: units still in the FIFO are flushed.
    build_frame(2, 64);
    clear_caps();
    send_frame(1'b0, 100, s);
    idle(70);
    verify_stream("t3 abort", 1'b0, s, 100 - L2);
    exp_dc++;
    check("t3 drop_count", dc, exp_dc);
    check("t3 frame_count", fc, exp_fc);

    // Oversized frame: MAX_UNITS accepted, then truncated; the last LATENCY units never leave.
    build_frame(2, 1517);
    void'(units.pop_back());
    void'(units.pop_back());
    clear_caps();
    send_frame(1'b0, -1, s);
    idle(70);
    verify_stream("t4 truncate", 1'b0, s, MAXU - L2);
    exp_dc++;
    check("t4 drop_count", dc, exp_dc);
    check("t4 frame_count", fc, exp_fc);
    check("t4 overflow", ovf, 0);

    // Abort on the same cycle as end-of-frame detection: dropped, not forwarded.
    build_frame(2, 16);
    n = units.size();
    clear_caps();
    send_frame(1'b0, n, s);
    idle(70);
    verify_stream("t7 abort at end", 1'b0, s, n - L2);
    exp_dc++;
    check("t7 drop_count", dc, exp_dc);
    check("t7 frame_count", fc, exp_fc);

    // Reset mid-frame; the remainder avoids the start pattern so it must not restart a frame.
    build_frame(2, 10);
    clear_caps();
    foreach (units[i]) begin
      drive(1'b0, 1'b1, units[i], 1'b0);
      tick();
    end
    check("t5 data_capture before rst", dcap, 1);
    check("t5 tx_en before rst", tx_en, 1);
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'h2, 1'b0);
    tick();
    rst = 1'b0;
    check("t5 tx_en after rst", tx_en, 0);
    check("t5 txd after rst", txd, 0);
    check("t5 data_capture after rst", dcap, 0);
    check("t5 frame_count after rst", fc, 0);
    check("t5 drop_count after rst", dc, 0);
    check("t5 overflow after rst", ovf, 0);
    clear_caps();
    for (int i = 0; i < 60; i++) begin
      v = 2'($urandom_range(0, 2));
      if (v == 2'b01) v = 2'b11;
      drive(1'b0, 1'b1, {2'b00, v}, 1'b0);
      tick();
    end
    idle(70);
    check("t5 tx after rst", cap2_d.size(), 0);
    check("t5 frame_count end", fc, 0);

    // DW=4, LATENCY=8: second frame 12 clocks after the first lands inside the gap and is lost.
    build_frame(4, 20);
    frame_a = units;
    clear_caps();
    send_frame(1'b1, -1, sa);
    idle(11);
    build_frame(4, 10);
    send_frame(1'b1, -1, sb);
    idle(100);
    units = frame_a;
    verify_stream("t6 dw4", 1'b1, sa, frame_a.size());
    check("t6 frame_count", fc4, 1);
    check("t6 drop_count", dc4, 0);
    check("t6 overflow", ovf4, 0);
    check("t6 second frame start edge", sb - sa, frame_a.size() + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
